subframe_encoder: RTL
=====================

Name: subframe_encoder

Overview:
Packs one FLAC subframe (VERBATIM or FIXED order 0..2, single Rice partition) into 16-bit RAM words. Sample-wise it is the inverse of the subframe decoder.
- Consumes signed 16-bit samples over a valid/ready handshake.
- Computes fixed-predictor residuals and Rice-codes them.
- Streams big-endian, MSB-first words to a RAM write port.
- Sits between the per-channel sample buffer and the frame assembler, which provides start address/byte alignment and collects the end position.

Parameters:
ACC_W, 32, width of the bit-packing accumulator (must be >= 32)

Ports:
iClock  in  1  clock
iReset  in  1  synchronous, active-high reset
iEnable  in  1  pipeline advances only when high; all state frozen when low
iStart  in  1  one-cycle pulse in IDLE; latches all configuration inputs below
iBlockSize  in  16  samples in subframe (1..65535)
iMode  in  1  0 = VERBATIM, 1 = FIXED
iOrder  in  2  fixed predictor order 0..2; 3 = illegal, encoded as VERBATIM
iRiceParam  in  4  Rice parameter k (0..14)
iUpperBits  in  1  1 = subframe starts at bit 15 of iStartAddress; 0 = starts at bit 7
iPrevByte  in  8  upper byte preserved in first word when iUpperBits = 0
iStartAddress  in  16  first RAM word address
iSample  in  16  signed input sample
iSampleValid  in  1  sample valid
oSampleReady  out  1  sample accepted when iSampleValid && oSampleReady && iEnable
oWriteEnable  out  1  one-cycle write strobe
oWriteAddr  out  16  RAM word address
oWriteData  out  16  RAM word data
oFrameDone  out  1  one-cycle pulse after final word written
oEndAddress  out  16  address of last word written (valid from oFrameDone until next iStart)
oEndBits  out  5  valid bits in last word, 1..16

Behaviour:
Reset values:
- oSampleReady = 0, oWriteEnable = 0, oFrameDone = 0.
- oWriteAddr, oWriteData, oEndAddress = 0; oEndBits = 0.
- State = IDLE; accumulator empty.
- iReset mid-subframe aborts immediately; no further writes occur.

States: IDLE -> HEADER -> (VERB | WARM -> CODING -> RESID -> UNARY*) -> FLUSH -> DONE -> IDLE.

Per-state behaviour:
- IDLE: iStart latches config.
  - Packer is preloaded with 8 bits = iPrevByte if iUpperBits = 0; else empty.
  - Write address = iStartAddress.
- HEADER: pushes 8 bits: 0, type[5:0], wasted-bits flag 0.
  - Type = 000001 for VERBATIM; 001ooo for FIXED.
- VERB: accepts iBlockSize samples; pushes 16 bits each.
- WARM: accepts iOrder samples; pushes 16 bits each. Skipped if order 0.
- CODING: pushes 10 bits: method 00, partition order 0000, k[3:0].
- RESID: accepts remaining iBlockSize - order samples.
  - Residual r is 18-bit signed: order 0 r = x; order 1 r = x - x1; order 2 r = x - 2*x1 + x2. x1/x2 are the previous accepted samples, including warm-up.
  - u = (r >= 0) ? 2r : -2r - 1 (19-bit unsigned); q = u >> k.
  - Emits q zeros, a 1, then u[k-1:0].
  - If q + 1 + k <= 16: one push.
  - Otherwise enter UNARY: push up to 16 zeros per cycle until the remainder fits, then push the terminator and low bits. oSampleReady = 0 while in UNARY.
- Packer: at most one RAM word per cycle.
  - Whenever the accumulator holds >= 16 bits, the top 16 bits are written at oWriteAddr; the address then increments (wraps 0xFFFF -> 0).
  - oSampleReady = 1 only in VERB/WARM/RESID when accumulator count <= ACC_W - 19 and no UNARY continuation is pending. A push and a word emit in the same cycle are both honoured.
- FLUSH: after the last sample, drain full words.
  - If bits remain, pad with zeros to 16 and write.
  - oEndAddress = that address; oEndBits = real bits in it (16 if none remained).
- DONE: oFrameDone pulses for 1 cycle, then IDLE.
- Boundaries:
  - iBlockSize <= order: no RESID samples; CODING is still emitted.
  - iStart outside IDLE is ignored.
  - Sample latency, accept to word write: <= 2 cycles when not stalled.

Optional Feature:
SUBFRAME_ENCODER_STATS_EN
- Defined: adds output oBitCount[23:0] = total subframe bits written, excluding the iPrevByte preload and padding. Cleared on iStart/iReset; valid with oFrameDone.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
1. VERBATIM, block 2, iUpperBits = 1, addr 0x0010, samples 0x1234, 0xABCD -> writes 0x0212@0x10, 0x34AB@0x11, 0xCD00@0x12; oEndAddress 0x12, oEndBits 8, oFrameDone 1 cycle.
2. VERBATIM, block 1, iUpperBits = 0, iPrevByte 0xAB, addr 0x0000, sample 0x5555 -> writes 0xAB02@0x0, 0x5555@0x1; oEndBits 16.
3. FIXED order 0, k = 0, block 2, samples 0, 1 -> writes 0x1000, 0x2400; oEndBits 6.
4. FIXED order 1, k = 1, block 3, samples 100, 101, 99 -> writes 0x1200, 0x6400, 0x5300; oEndBits 8.
5. FIXED order 0, k = 0, sample -32768 (u = 65535) -> 4096 cycles of UNARY with oSampleReady low; 4096 zero words then terminator; iSampleValid held high meanwhile is not consumed.
6. iReset asserted mid-RESID, then new iStart with test 1 config -> no stray writes; output identical to test 1.

Source files
------------

// File: rtl/subframe_encoder.sv
// FLAC subframe packer: VERBATIM or FIXED (order 0..2) with one Rice partition, emitted as
// big-endian 16-bit RAM words. Define SUBFRAME_ENCODER_STATS_EN to add the oBitCount output.
module subframe_encoder #(
    parameter int unsigned ACC_W = 32
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iEnable,
    input  logic        iStart,
    input  logic [15:0] iBlockSize,
    input  logic        iMode,
    input  logic [1:0]  iOrder,
    input  logic [3:0]  iRiceParam,
    input  logic        iUpperBits,
    input  logic [7:0]  iPrevByte,
    input  logic [15:0] iStartAddress,
    input  logic [15:0] iSample,
    input  logic        iSampleValid,
    output logic        oSampleReady,
    output logic        oWriteEnable,
    output logic [15:0] oWriteAddr,
    output logic [15:0] oWriteData,
    output logic        oFrameDone,
    output logic [15:0] oEndAddress,
    output logic [4:0]  oEndBits
`ifdef SUBFRAME_ENCODER_STATS_EN
    ,
    output logic [23:0] oBitCount
`endif
);

    localparam int unsigned CW = $clog2(ACC_W + 1);
    localparam logic [CW-1:0] WORD_BITS = CW'(16);
    localparam logic [CW-1:0] READY_MAX = CW'(ACC_W - 19);

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_HEADER = 4'd1;
    localparam logic [3:0] ST_VERB   = 4'd2;
    localparam logic [3:0] ST_WARM   = 4'd3;
    localparam logic [3:0] ST_CODING = 4'd4;
    localparam logic [3:0] ST_RESID  = 4'd5;
    localparam logic [3:0] ST_UNARY  = 4'd6;
    localparam logic [3:0] ST_FLUSH  = 4'd7;
    localparam logic [3:0] ST_DONE   = 4'd8;

    logic [3:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic             verbatim_q, verbatim_d;
    logic [1:0]       order_q, order_d;
    logic [3:0]       k_q, k_d;
    logic [15:0]      block_q, block_d;
    logic [15:0]      rem_q, rem_d;
    logic [15:0]      x1_q, x1_d;
    logic [15:0]      x2_q, x2_d;
    logic [18:0]      qrem_q, qrem_d;
    logic [15:0]      term_q, term_d;
    logic             we_q, we_d;
    logic [15:0]      wdata_q, wdata_d;
    logic [15:0]      waddr_q, waddr_d;
    logic             done_q, done_d;
    logic [15:0]      end_addr_q, end_addr_d;
    logic [4:0]       end_bits_q, end_bits_d;

    logic             emit;
    logic [CW-1:0]    cnt_mid;
    logic [ACC_W-1:0] acc_mid;
    logic [ACC_W-1:0] placed;
    logic             push_en;
    logic [4:0]       push_len;
    logic [15:0]      push_val;
    logic             load;
    logic             pad;
    logic             ready;
    logic             accept;
    logic [15:0]      warm_cnt;

    logic signed [17:0] x_ext, x1_ext, x2_ext, resid;
    logic [18:0]      r2, u, q_val, low_mask;
    logic [15:0]      term_val;
    logic             fits;
    logic [4:0]       single_len;
    logic             ufits;
    logic [4:0]       zrun;
    logic [7:0]       header_byte;

    assign ready = ((state_q == ST_VERB) || (state_q == ST_WARM) || (state_q == ST_RESID)) &&
                   (cnt_q <= READY_MAX);
    assign accept = iSampleValid && ready;
    assign warm_cnt = (block_q < {14'd0, order_q}) ? block_q : {14'd0, order_q};
    assign header_byte = verbatim_q ? 8'b0_000001_0 : {1'b0, 3'b001, 1'b0, order_q, 1'b0};

    // Residual and zigzag mapping; -2r-1 is the bitwise complement of 2r.
    always_comb begin
        x_ext  = {{2{iSample[15]}}, iSample};
        x1_ext = {{2{x1_q[15]}}, x1_q};
        x2_ext = {{2{x2_q[15]}}, x2_q};
        case (order_q)
            2'd1:    resid = x_ext - x1_ext;
            2'd2:    resid = x_ext - (x1_ext <<< 1) + x2_ext;
            default: resid = x_ext;
        endcase
        r2         = {resid, 1'b0};
        u          = resid[17] ? ~r2 : r2;
        q_val      = u >> k_q;
        low_mask   = (19'd1 << k_q) - 19'd1;
        term_val   = 16'((19'd1 << k_q) | (u & low_mask));
        fits       = ({1'b0, q_val} + 20'(k_q) + 20'd1) <= 20'd16;
        single_len = q_val[4:0] + {1'b0, k_q} + 5'd1;
        ufits      = ({1'b0, qrem_q} + 20'(k_q) + 20'd1) <= 20'd16;
        zrun       = (qrem_q >= 19'd16) ? 5'd16 : qrem_q[4:0];
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        verbatim_d = verbatim_q;
        order_d    = order_q;
        k_d        = k_q;
        block_d    = block_q;
        rem_d      = rem_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        qrem_d     = qrem_q;
        term_d     = term_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        waddr_d    = waddr_q;
        done_d     = 1'b0;
        end_addr_d = end_addr_q;
        end_bits_d = end_bits_q;
        push_en    = 1'b0;
        push_len   = 5'd0;
        push_val   = 16'd0;
        load       = 1'b0;
        pad        = 1'b0;

        emit    = (cnt_q >= WORD_BITS);
        cnt_mid = emit ? (cnt_q - WORD_BITS) : cnt_q;
        acc_mid = emit ? (acc_q << 16) : acc_q;
        if (emit) begin
            we_d    = 1'b1;
            wdata_d = acc_q[ACC_W-1 -: 16];
            waddr_d = addr_q;
            addr_d  = addr_q + 16'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    load       = 1'b1;
                    verbatim_d = ~iMode || (iOrder == 2'd3);
                    order_d    = (~iMode || (iOrder == 2'd3)) ? 2'd0 : iOrder;
                    k_d        = iRiceParam;
                    block_d    = iBlockSize;
                    addr_d     = iStartAddress;
                    state_d    = ST_HEADER;
                end
            end
            ST_HEADER: begin
                push_en  = 1'b1;
                push_len = 5'd8;
                push_val = {8'd0, header_byte};
                if (verbatim_q) begin
                    rem_d   = block_q;
                    state_d = ST_VERB;
                end else if (warm_cnt != 16'd0) begin
                    rem_d   = warm_cnt;
                    state_d = ST_WARM;
                end else begin
                    state_d = ST_CODING;
                end
            end
            ST_VERB: begin
                if (accept) begin
                    push_en  = 1'b1;
                    push_len = 5'd16;
                    push_val = iSample;
                    rem_d    = rem_q - 16'd1;
                    if (rem_q <= 16'd1) state_d = ST_FLUSH;
                end
            end
            ST_WARM: begin
                if (accept) begin
                    push_en  = 1'b1;
                    push_len = 5'd16;
                    push_val = iSample;
                    x1_d     = iSample;
                    x2_d     = x1_q;
                    rem_d    = rem_q - 16'd1;
                    if (rem_q <= 16'd1) state_d = ST_CODING;
                end
            end
            ST_CODING: begin
                push_en  = 1'b1;
                push_len = 5'd10;
                push_val = {12'd0, k_q};
                rem_d    = block_q - warm_cnt;
                state_d  = (block_q == warm_cnt) ? ST_FLUSH : ST_RESID;
            end
            ST_RESID: begin
                if (accept) begin
                    x1_d  = iSample;
                    x2_d  = x1_q;
                    rem_d = rem_q - 16'd1;
                    if (fits) begin
                        push_en  = 1'b1;
                        push_len = single_len;
                        push_val = term_val;
                        if (rem_q <= 16'd1) state_d = ST_FLUSH;
                    end else begin
                        qrem_d  = q_val;
                        term_d  = term_val;
                        state_d = ST_UNARY;
                    end
                end
            end
            ST_UNARY: begin
                push_en = 1'b1;
                if (ufits) begin
                    push_len = qrem_q[4:0] + {1'b0, k_q} + 5'd1;
                    push_val = term_q;
                    state_d  = (rem_q == 16'd0) ? ST_FLUSH : ST_RESID;
                end else begin
                    push_len = zrun;
                    qrem_d   = qrem_q - {14'd0, zrun};
                end
            end
            ST_FLUSH: begin
                if (!emit) begin
                    state_d = ST_DONE;
                    if (cnt_q != '0) begin
                        pad        = 1'b1;
                        we_d       = 1'b1;
                        wdata_d    = acc_q[ACC_W-1 -: 16];
                        waddr_d    = addr_q;
                        addr_d     = addr_q + 16'd1;
                        end_addr_d = addr_q;
                        end_bits_d = cnt_q[4:0];
                    end else begin
                        end_addr_d = addr_q - 16'd1;
                        end_bits_d = 5'd16;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Left-justify the push within 16 bits, then drop it just below the valid bits.
        placed = {16'(push_val << (5'd16 - push_len)), {(ACC_W - 16){1'b0}}} >> cnt_mid;

        if (load) begin
            acc_d = iUpperBits ? '0 : {iPrevByte, {(ACC_W - 8){1'b0}}};
            cnt_d = iUpperBits ? '0 : CW'(8);
        end else if (pad) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (push_en) begin
            acc_d = acc_mid | placed;
            cnt_d = cnt_mid + CW'(push_len);
        end else begin
            acc_d = acc_mid;
            cnt_d = cnt_mid;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= 16'd0;
            verbatim_q <= 1'b0;
            order_q    <= 2'd0;
            k_q        <= 4'd0;
            block_q    <= 16'd0;
            rem_q      <= 16'd0;
            x1_q       <= 16'd0;
            x2_q       <= 16'd0;
            qrem_q     <= 19'd0;
            term_q     <= 16'd0;
            we_q       <= 1'b0;
            wdata_q    <= 16'd0;
            waddr_q    <= 16'd0;
            done_q     <= 1'b0;
            end_addr_q <= 16'd0;
            end_bits_q <= 5'd0;
        end else if (iEnable) begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            verbatim_q <= verbatim_d;
            order_q    <= order_d;
            k_q        <= k_d;
            block_q    <= block_d;
            rem_q      <= rem_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            qrem_q     <= qrem_d;
            term_q     <= term_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            waddr_q    <= waddr_d;
            done_q     <= done_d;
            end_addr_q <= end_addr_d;
            end_bits_q <= end_bits_d;
        end else begin
            // Strobes must not repeat while the pipeline is held.
            we_q   <= 1'b0;
            done_q <= 1'b0;
        end
    end

`ifdef SUBFRAME_ENCODER_STATS_EN
    logic [23:0] bit_count_q;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            bit_count_q <= 24'd0;
        end else if (iEnable) begin
            if (load) begin
                bit_count_q <= 24'd0;
            end else if (push_en) begin
                bit_count_q <= bit_count_q + 24'(push_len);
            end
        end
    end

    assign oBitCount = bit_count_q;
`endif

    assign oSampleReady = ready;
    assign oWriteEnable = we_q;
    assign oWriteAddr   = waddr_q;
    assign oWriteData   = wdata_q;
    assign oFrameDone   = done_q;
    assign oEndAddress  = end_addr_q;
    assign oEndBits     = end_bits_q;

endmodule
